// File: rtl/vdp_linebuf_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vdp_linebuf_reader
// Brief    : Read-side controller for the ping-pong VDP line buffers; scans one
//            bank per output line, repeats source lines and swaps banks.
// Revision : 1.0
// ============================================================================
module vdp_linebuf_reader #(
    parameter int WIDTH  = 640,
    parameter int REPEAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_line_done,
    input  logic       i_wr_bank,
    input  logic       i_field_start,
    input  logic       i_start,
    input  logic [5:0] i_q0,
    input  logic [5:0] i_q1,
    output logic [9:0] o_rd_address,
    output logic       o_rd_bank,
    output logic [5:0] o_pixel,
    output logic       o_pixel_valid,
    output logic       o_line_end,
    output logic       o_underrun,
    output logic       o_overrun
);

    localparam logic [9:0] c_LAST_ADDR = 10'(WIDTH - 1);
    localparam logic [1:0] c_LAST_REP  = 2'(REPEAT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_rep_cnt;
    logic       r_pend;
    logic       r_pend_bank;

    // Stage 1 tracks the address issued last cycle, aligned with bank data
    logic       r_v1;
    logic       r_b1;
    logic       r_last1;

    logic       w_accept;
    logic [1:0] w_rep_eff;
    logic       w_boundary;
    logic       w_consume;
    logic       w_issue;
    logic       w_issue_last;

    assign w_accept     = i_start && (r_state == S_IDLE);
    assign w_rep_eff    = i_field_start ? 2'd0 : r_rep_cnt;
    assign w_boundary   = w_accept && (w_rep_eff == 2'd0);
    assign w_consume    = w_boundary && r_pend;
    assign w_issue      = (r_state == S_SCAN);
    assign w_issue_last = w_issue && (o_rd_address == c_LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            o_rd_address <= '0;
            o_rd_bank    <= 1'b0;
            r_rep_cnt    <= 2'd0;
            r_pend       <= 1'b0;
            r_pend_bank  <= 1'b0;
            o_underrun   <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_underrun <= w_boundary && !r_pend;
            // A boundary on the same edge takes the old pending bank first
            o_overrun  <= i_line_done && r_pend && !w_consume;

            case (r_state)
                S_IDLE: begin
                    o_rd_address <= '0;
                    if (i_start) begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (o_rd_address == c_LAST_ADDR) begin
                        r_state      <= S_IDLE;
                        o_rd_address <= '0;
                    end else begin
                        o_rd_address <= o_rd_address + 10'd1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_rd_address <= '0;
                end
            endcase

            if (w_accept) begin
                r_rep_cnt <= (w_rep_eff == c_LAST_REP) ? 2'd0 : w_rep_eff + 2'd1;
            end else if (i_field_start) begin
                r_rep_cnt <= 2'd0;
            end

            if (w_consume) begin
                o_rd_bank <= r_pend_bank;
            end

            if (i_line_done) begin
                r_pend      <= 1'b1;
                r_pend_bank <= i_wr_bank;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1          <= 1'b0;
            r_b1          <= 1'b0;
            r_last1       <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_line_end    <= 1'b0;
            o_pixel       <= '0;
        end else begin
            r_v1          <= w_issue;
            r_b1          <= o_rd_bank;
            r_last1       <= w_issue_last;
            o_pixel_valid <= r_v1;
            o_line_end    <= r_last1;
            o_pixel       <= r_v1 ? (r_b1 ? i_q1 : i_q0) : 6'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vdp_linebuf_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vdp_linebuf_reader
// Brief    : Randomised scoreboard bench for the line buffer reader.
// Revision : 1.0
// ============================================================================
module tb_vdp_linebuf_reader;

    localparam int WIDTH  = 640;
    localparam int REPEAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_line_done = 1'b0;
    logic       i_wr_bank = 1'b0;
    logic       i_field_start = 1'b0;
    logic       i_start = 1'b0;
    logic [5:0] i_q0 = '0;
    logic [5:0] i_q1 = '0;
    logic [9:0] o_rd_address;
    logic       o_rd_bank;
    logic [5:0] o_pixel;
    logic       o_pixel_valid;
    logic       o_line_end;
    logic       o_underrun;
    logic       o_overrun;

    vdp_linebuf_reader #(.WIDTH(WIDTH), .REPEAT(REPEAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_line_done   (i_line_done),
        .i_wr_bank     (i_wr_bank),
        .i_field_start (i_field_start),
        .i_start       (i_start),
        .i_q0          (i_q0),
        .i_q1          (i_q1),
        .o_rd_address  (o_rd_address),
        .o_rd_bank     (o_rd_bank),
        .o_pixel       (o_pixel),
        .o_pixel_valid (o_pixel_valid),
        .o_line_end    (o_line_end),
        .o_underrun    (o_underrun),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line buffer banks with registered read address
    logic [5:0] mem [2][WIDTH];
    always @(posedge clk) begin
        i_q0 <= mem[0][o_rd_address];
        i_q1 <= mem[1][o_rd_address];
    end

    typedef struct { int cyc; logic [5:0] pix; logic last; } exp_pix_t;
    typedef struct { int cyc; logic bank; } exp_bank_t;
    exp_pix_t  pix_q[$];
    exp_bank_t bank_q[$];
    int        under_q[$];
    int        over_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 1'b0;

    // Reference state
    bit m_pend, m_pbank, m_bank;
    int m_cnt, m_busy_until;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_pbank = 0; m_bank = 0; m_cnt = 0; m_busy_until = cyc;
        pix_q.delete(); bank_q.delete(); under_q.delete(); over_q.delete();
    endtask

    task automatic model_cycle(input bit s, input bit ld, input bit wb, input bit fs);
        bit acc, bnd;
        int eff;
        acc = s && (cyc >= m_busy_until);
        eff = fs ? 0 : m_cnt;
        bnd = acc && (eff == 0);
        if (bnd) begin
            if (m_pend) begin
                m_bank = m_pbank;
                m_pend = 0;
            end else begin
                under_q.push_back(cyc + 1);
            end
        end
        if (acc) begin
            m_cnt = (eff + 1) % REPEAT;
            m_busy_until = cyc + WIDTH + 1;
            bank_q.push_back('{cyc + 1, m_bank});
            bank_q.push_back('{cyc + WIDTH, m_bank});
            for (int k = 0; k < WIDTH; k++)
                pix_q.push_back('{cyc + 3 + k, mem[m_bank][k], k == WIDTH - 1});
        end else if (fs) begin
            m_cnt = 0;
        end
        if (ld) begin
            if (m_pend) over_q.push_back(cyc + 1);
            m_pend = 1;
            m_pbank = wb;
        end
    endtask

    task automatic drive(input bit s, input bit ld, input bit wb, input bit fs);
        i_start = s; i_line_done = ld; i_wr_bank = wb; i_field_start = fs;
        model_cycle(s, ld, wb, fs);
        @(negedge clk);
        i_start = 0; i_line_done = 0; i_wr_bank = 0; i_field_start = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic fill(input bit b, input bit pattern);
        for (int k = 0; k < WIDTH; k++)
            mem[b][k] = pattern ? 6'((k % 32) << 1) : 6'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, o_rd_address, 0);
        chk({tag, "_bank"}, o_rd_bank, 0);
        chk({tag, "_pixel"}, o_pixel, 0);
        chk({tag, "_valid"}, o_pixel_valid, 0);
        chk({tag, "_line_end"}, o_line_end, 0);
        chk({tag, "_underrun"}, o_underrun, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents output
    always @(negedge clk) begin
        if (rst_n && !done) begin
            bit exp_u, exp_o;
            if (o_pixel_valid) begin
                if (pix_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    exp_pix_t e;
                    e = pix_q.pop_front();
                    chk("pixel", o_pixel, e.pix);
                    chk("pixel_cycle", cyc, e.cyc);
                    chk("line_end", o_line_end, e.last);
                end
            end else begin
                if (o_pixel != 0) chk("idle_pixel", o_pixel, 0);
                if (o_line_end) chk("idle_line_end", o_line_end, 0);
                if (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
                    chk("missing_pixel", cyc, pix_q[0].cyc);
                    void'(pix_q.pop_front());
                end
            end
            exp_u = (under_q.size() > 0 && under_q[0] == cyc);
            if (exp_u) void'(under_q.pop_front());
            if (exp_u || o_underrun) chk("underrun", o_underrun, exp_u);
            exp_o = (over_q.size() > 0 && over_q[0] == cyc);
            if (exp_o) void'(over_q.pop_front());
            if (exp_o || o_overrun) chk("overrun", o_overrun, exp_o);
            while (bank_q.size() > 0 && bank_q[0].cyc <= cyc) begin
                exp_bank_t eb;
                eb = bank_q.pop_front();
                chk("rd_bank", o_rd_bank, eb.bank);
            end
        end
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < WIDTH; k++) mem[b][k] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_reset();
        idle(2);

        // Basic scan from bank0 with the ramp pattern
        fill(0, 1); drive(0, 1, 0, 0); idle(3);
        drive(1, 0, 0, 0); idle(WIDTH + 10);
        drive(1, 0, 0, 0); idle(WIDTH + 4);

        // Double scan: bank1 written during the first line, STARTs back to back
        fill(0, 0); drive(0, 1, 0, 0); idle(2);
        drive(1, 0, 0, 0); idle(50);
        fill(1, 0); drive(0, 1, 1, 0); idle(WIDTH - 51);
        drive(1, 0, 0, 0); idle(WIDTH);
        drive(1, 0, 0, 0); idle(WIDTH);
        drive(1, 0, 0, 0); idle(WIDTH + 5);

        // Underrun: boundary with nothing pending repeats bank1
        drive(1, 0, 0, 0); idle(WIDTH);
        drive(1, 0, 0, 0); idle(WIDTH + 5);

        // Overrun: second LINE_DONE replaces the pending bank
        drive(0, 1, 1, 0); idle(3);
        fill(0, 0); drive(0, 1, 0, 0); idle(3);
        drive(1, 0, 0, 0); idle(WIDTH);
        drive(1, 0, 0, 0); idle(WIDTH + 5);

        // LINE_DONE coincident with a boundary START, plus an ignored mid-scan START
        fill(1, 0); drive(0, 1, 1, 0); idle(3);
        drive(1, 1, 0, 0); idle(10);
        fill(0, 0); idle(WIDTH - 10);
        drive(1, 0, 0, 0); idle(100);
        drive(1, 0, 0, 0); idle(WIDTH - 101);
        drive(1, 0, 0, 0); idle(WIDTH + 5);

        // FIELD_START realigns the repeat phase
        drive(0, 0, 0, 1); idle(2);
        fill(1, 0); drive(0, 1, 1, 0); idle(2);
        drive(1, 0, 0, 0); idle(WIDTH + 3);
        drive(1, 0, 0, 1); idle(WIDTH + 3);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            bit b, ld;
            idle($urandom_range(0, 300));
            b  = 1'($urandom);
            ld = ($urandom % 3) == 0;
            if (ld && !(cyc < m_busy_until && b == m_bank)) fill(b, 0);
            drive(1'($urandom), ld, b, ($urandom % 5) == 0);
        end
        idle(WIDTH + 5);

        // Reset in the middle of a scan
        drive(1, 0, 0, 0); idle(199);
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3);
        drive(1, 0, 0, 0); idle(WIDTH + 10);

        done = 1'b1;
        chk("leftover_pixels", pix_q.size(), 0);
        chk("leftover_underrun", under_q.size(), 0);
        chk("leftover_overrun", over_q.size(), 0);
        chk("leftover_bank", bank_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
